dmem_arbiter: RTL and testbench

- Shares the single data port of the memory subsystem (dread/dwrite to ROM+RAM) between two masters: m0 = CPU data unit, m1 = debug/DMA loader.
- Fixed priority to m0, with a starvation counter that forces a grant to m1 after MAXWAIT waiting cycles.
- Supports a lock so one master can hold the port for back-to-back read-modify-write.
- Sits between the masters and the memory subsystem; the instruction port bypasses this block.

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arbiter_if.sv | 55 +++++
 rtl/dmem_rsp_route.sv | 49 ++++
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types for the data-port arbiter: owner state encoding, the
//   read-enable constant and the per-master request bundle.
package dmem_arb_pkg;

  localparam int DMEM_AW = 16;
  localparam int DMEM_DW = 16;

  // A byte-enable of zero means the access is a read.
  localparam logic [1:0] WE_READ = 2'b00;

  // State records only which master (if any) holds the lock.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  typedef struct packed {
    logic [DMEM_AW-1:0] addr;
    logic [1:0]         we;
    logic [DMEM_DW-1:0] wdata;
    logic               lock;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles both master request/response channels and the memory data port.
//   slave  : the arbiter's view (requests in, grants/responses/memory out).
//   master : the masters' and memory's view (the mirror image).
//
// Handshake: mX_req is a level request held until mX_gnt. mX_gnt is a
// same-cycle acceptance; the access is issued to memory in that cycle.
// There is no back-pressure on responses: mX_rvalid is a one-cycle pulse
// that must be consumed when it appears.
interface dmem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          m0_req;
  logic          m0_lock;
  logic [AW-1:0] m0_addr;
  logic [1:0]    m0_we;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic [1:0]    m1_we;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] dread_addr;
  logic [DW-1:0] dread_data;
  logic [AW-1:0] dwrite_addr;
  logic [DW-1:0] dwrite_data;
  logic [1:0]    dwrite_en;

  modport slave (
    input  m0_req, m0_lock, m0_addr, m0_we, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_lock, m1_addr, m1_we, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output dread_addr, dwrite_addr, dwrite_data, dwrite_en,
    input  dread_data
  );

  modport master (
    output m0_req, m0_lock, m0_addr, m0_we, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_lock, m1_addr, m1_we, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  dread_addr, dwrite_addr, dwrite_data, dwrite_en,
    output dread_data
  );
endinterface

// File: rtl/dmem_rsp_route.sv
// dmem_rsp_route
//   One-cycle tag/valid pipeline that steers the registered memory read data
//   back to whichever master issued the read.
//   Ports: clk, reset; issue_rd/issue_tag (read issued this cycle, 1 = m1);
//          dread_data from memory; mX_rvalid/mX_rdata to the masters.
module dmem_rsp_route #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_rd,
  input  logic          issue_tag,
  input  logic [DW-1:0] dread_data,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata
);
  logic          pend_q, pend_d;
  logic          tag_q, tag_d;
  logic [DW-1:0] hold0_q, hold0_d;
  logic [DW-1:0] hold1_q, hold1_d;

  always_comb begin
    pend_d  = issue_rd;
    tag_d   = issue_rd ? issue_tag : tag_q;
    // Gating with reset kills a read that was in flight when reset hit.
    m0_rvalid = pend_q && !tag_q && !reset;
    m1_rvalid = pend_q &&  tag_q && !reset;
    hold0_d = m0_rvalid ? dread_data : hold0_q;
    hold1_d = m1_rvalid ? dread_data : hold1_q;
    m0_rdata = reset ? '0 : hold0_d;
    m1_rdata = reset ? '0 : hold1_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= 1'b0;
      tag_q   <= 1'b0;
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      pend_q  <= pend_d;
      tag_q   <= tag_d;
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single memory data port between m0 (CPU data unit, priority)
//   and m1 (debug/DMA loader). m1 is forced through after MAXWAIT waiting
//   cycles; a lock lets a master hold the port for read-modify-write, but a
//   lock streak of MAXWAIT grants yields one cycle to a waiting other master.
//   Ports: clk, reset (sync, active-high); bus (slave modport: both master
//   channels plus the memory data port); dbg_state (current owner state).
//   DW is expected to be 16.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAXWAIT = 8,
  parameter int AW      = DMEM_AW,
  parameter int DW      = DMEM_DW
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus,
  output state_e         dbg_state
);
  localparam logic [7:0] MAXW = 8'(MAXWAIT);

  state_e        state_q, state_d;
  logic [7:0]    wait_q, wait_d;
  logic [7:0]    streak_q, streak_d;
  logic [AW-1:0] addr_q, addr_d;
  // Low during reset and the cycle after it, so nothing is issued then.
  logic          live_q;
  logic          gnt0, gnt1, granted, issue_rd;
  dmem_req_t     req0, req1, win;

  always_comb begin
    req0.addr  = bus.m0_addr;
    req0.we    = bus.m0_we;
    req0.wdata = bus.m0_wdata;
    req0.lock  = bus.m0_lock;
    req1.addr  = bus.m1_addr;
    req1.we    = bus.m1_we;
    req1.wdata = bus.m1_wdata;
    req1.lock  = bus.m1_lock;

    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (live_q && !reset) begin
      if (state_q == OWN0 && bus.m0_req) begin
        // Owner keeps the port unless its streak has starved m1.
        if (bus.m1_req && streak_q == MAXW) gnt1 = 1'b1;
        else                                 gnt0 = 1'b1;
      end else if (state_q == OWN1 && bus.m1_req) begin
        if (bus.m0_req && streak_q == MAXW) gnt0 = 1'b1;
        else                                 gnt1 = 1'b1;
      end else if (bus.m1_req && wait_q == MAXW) begin
        gnt1 = 1'b1;
      end else if (bus.m0_req) begin
        gnt0 = 1'b1;
      end else if (bus.m1_req) begin
        gnt1 = 1'b1;
      end
    end
    granted = gnt0 || gnt1;
    win     = gnt1 ? req1 : req0;

    // Address outputs hold the last issued address when idle.
    addr_d          = granted ? win.addr : addr_q;
    bus.dread_addr  = addr_d;
    bus.dwrite_addr = addr_d;
    bus.dwrite_en   = granted ? win.we : WE_READ;
    bus.dwrite_data = granted ? win.wdata : '0;
    bus.m0_gnt      = gnt0;
    bus.m1_gnt      = gnt1;
    issue_rd        = granted && (win.we == WE_READ);

    state_d = IDLE;
    if (granted && win.lock) state_d = gnt1 ? OWN1 : OWN0;

    wait_d = wait_q;
    if (!bus.m1_req || gnt1)  wait_d = '0;
    else if (wait_q < MAXW)   wait_d = wait_q + 8'd1;

    streak_d = streak_q;
    if (state_d != state_q)
      streak_d = '0;
    else if (((state_q == OWN0 && gnt0) || (state_q == OWN1 && gnt1)) && streak_q < MAXW)
      streak_d = streak_q + 8'd1;

    dbg_state = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      streak_q <= '0;
      addr_q   <= '0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      live_q   <= 1'b1;
    end
  end

  dmem_rsp_route #(.DW(DW)) u_rsp (
    .clk        (clk),
    .reset      (reset),
    .issue_rd   (issue_rd),
    .issue_tag  (gnt1),
    .dread_data (bus.dread_data),
    .m0_rvalid  (bus.m0_rvalid),
    .m0_rdata   (bus.m0_rdata),
    .m1_rvalid  (bus.m1_rvalid),
    .m1_rdata   (bus.m1_rdata)
  );
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with MAXWAIT=8. Inputs change just after
//   the falling edge; outputs are checked 1 time unit later.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic   clk;
  logic   reset;
  state_e dbg_state;
  int     checks;
  int     failures;
  logic [15:0] mem [0:32767];

  dmem_arbiter_if #(.AW(16), .DW(16)) bus ();

  dmem_arbiter #(.MAXWAIT(8), .AW(16), .DW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-organised memory with byte strobes and registered read data.
  always @(posedge clk) begin
    bus.dread_data <= mem[bus.dread_addr[15:1]];
    if (bus.dwrite_en[0]) mem[bus.dwrite_addr[15:1]][7:0]  <= bus.dwrite_data[7:0];
    if (bus.dwrite_en[1]) mem[bus.dwrite_addr[15:1]][15:8] <= bus.dwrite_data[15:8];
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.m0_req = 0; bus.m0_lock = 0; bus.m0_addr = '0; bus.m0_we = 2'b00; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_lock = 0; bus.m1_addr = '0; bus.m1_we = 2'b00; bus.m1_wdata = '0;
  endtask

  task automatic set_m0(input logic lock, input logic [15:0] addr, input logic [1:0] we, input logic [15:0] wd);
    bus.m0_req = 1; bus.m0_lock = lock; bus.m0_addr = addr; bus.m0_we = we; bus.m0_wdata = wd;
  endtask

  task automatic set_m1(input logic lock, input logic [15:0] addr, input logic [1:0] we, input logic [15:0] wd);
    bus.m1_req = 1; bus.m1_lock = lock; bus.m1_addr = addr; bus.m1_we = we; bus.m1_wdata = wd;
  endtask

  task automatic idle_cycle();
    cyc(); clear_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) cyc();
    // Write presented during reset must not be issued.
    set_m0(1'b0, 16'h1111, 2'b11, 16'h7777);
    #1;
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.dwrite_en} !== 4'b0000) begin
      failures++; $display("FAIL reset_no_issue: gnt/en=%b want 0000", {bus.m0_gnt, bus.m1_gnt, bus.dwrite_en});
    end
    checks++;
    if (dbg_state !== IDLE || bus.dread_addr !== 16'h0000) begin
      failures++; $display("FAIL reset_state: state=%0d addr=%h want 0/0000", dbg_state, bus.dread_addr);
    end
    checks++;
    if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata} !== 34'd0) begin
      failures++; $display("FAIL reset_rsp: rv0=%b rv1=%b rd0=%h rd1=%h want zeros",
                           bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata);
    end
    cyc();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.dwrite_en !== 2'b00 || bus.m0_gnt !== 1'b0) begin
      failures++; $display("FAIL reset_after: en=%b gnt0=%b want 00/0", bus.dwrite_en, bus.m0_gnt);
    end
    clear_inputs();
  endtask

  task automatic test_single_read();
    cyc(); set_m0(1'b0, 16'h4002, 2'b00, 16'h0000); #1;
    checks++;
    if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0 || bus.dread_addr !== 16'h4002 || bus.dwrite_en !== 2'b00) begin
      failures++; $display("FAIL single_issue: gnt0=%b gnt1=%b addr=%h en=%b want 1/0/4002/00",
                           bus.m0_gnt, bus.m1_gnt, bus.dread_addr, bus.dwrite_en);
    end
    cyc(); clear_inputs(); #1;
    checks++;
    if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 16'h1234 || bus.m1_rvalid !== 1'b0) begin
      failures++; $display("FAIL single_rsp: rv0=%b rd0=%h rv1=%b want 1/1234/0", bus.m0_rvalid, bus.m0_rdata, bus.m1_rvalid);
    end
    cyc(); #1;
    checks++;
    if (bus.m0_rvalid !== 1'b0 || bus.m0_rdata !== 16'h1234 || bus.dread_addr !== 16'h4002) begin
      failures++; $display("FAIL single_hold: rv0=%b rd0=%h addr=%h want 0/1234/4002", bus.m0_rvalid, bus.m0_rdata, bus.dread_addr);
    end
  endtask

  task automatic test_simultaneous();
    cyc();
    set_m0(1'b0, 16'h0100, 2'b11, 16'hBEEF);
    set_m1(1'b0, 16'h0200, 2'b10, 16'h1357);
    #1;
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10 || bus.dwrite_en !== 2'b11 || bus.dwrite_data !== 16'hBEEF || bus.dwrite_addr !== 16'h0100) begin
      failures++; $display("FAIL simul_m0: gnt=%b en=%b data=%h addr=%h want 10/11/beef/0100",
                           {bus.m0_gnt, bus.m1_gnt}, bus.dwrite_en, bus.dwrite_data, bus.dwrite_addr);
    end
    cyc(); bus.m0_req = 0; #1;
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01 || bus.dwrite_en !== 2'b10 || bus.dwrite_data !== 16'h1357 || bus.dwrite_addr !== 16'h0200) begin
      failures++; $display("FAIL simul_m1: gnt=%b en=%b data=%h addr=%h want 01/10/1357/0200",
                           {bus.m0_gnt, bus.m1_gnt}, bus.dwrite_en, bus.dwrite_data, bus.dwrite_addr);
    end
    cyc(); clear_inputs(); #1;
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.dwrite_en, bus.m0_rvalid, bus.m1_rvalid} !== 6'd0 || bus.dwrite_addr !== 16'h0200) begin
      failures++; $display("FAIL simul_quiet: gnt=%b en=%b rv=%b addr=%h want 00/00/00/0200",
                           {bus.m0_gnt, bus.m1_gnt}, bus.dwrite_en, {bus.m0_rvalid, bus.m1_rvalid}, bus.dwrite_addr);
    end
    // Read back the upper-byte-only write of m1 (word started as zero).
    set_m1(1'b0, 16'h0200, 2'b00, 16'h0000);
    cyc(); clear_inputs(); #1;
    checks++;
    if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 16'h1300) begin
      failures++; $display("FAIL simul_readback: rv1=%b rd1=%h want 1/1300", bus.m1_rvalid, bus.m1_rdata);
    end
  endtask

  task automatic test_starvation();
    logic [1:0] exp;
    idle_cycle();
    cyc();
    set_m0(1'b0, 16'h0300, 2'b11, 16'h0001);
    set_m1(1'b0, 16'h0302, 2'b11, 16'h0002);
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) cyc();
      #1;
      exp = (c == 9) ? 2'b01 : 2'b10;
      checks++;
      if ({bus.m0_gnt, bus.m1_gnt} !== exp) begin
        failures++; $display("FAIL starve_cycle%0d: gnt=%b want %b", c, {bus.m0_gnt, bus.m1_gnt}, exp);
      end
    end
    clear_inputs();
  endtask

  task automatic test_lock_streak();
    logic [1:0] exp;
    idle_cycle();
    cyc();
    set_m0(1'b1, 16'h0400, 2'b11, 16'h0003);
    set_m1(1'b0, 16'h0402, 2'b11, 16'h0004);
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) cyc();
      #1;
      exp = (c == 10) ? 2'b01 : 2'b10;
      checks++;
      if ({bus.m0_gnt, bus.m1_gnt} !== exp) begin
        failures++; $display("FAIL streak_cycle%0d: gnt=%b want %b", c, {bus.m0_gnt, bus.m1_gnt}, exp);
      end
      if (c == 10) begin
        checks++;
        if (dbg_state !== OWN0) begin
          failures++; $display("FAIL streak_state10: state=%0d want %0d", dbg_state, OWN0);
        end
      end
      if (c == 11) begin
        checks++;
        if (dbg_state !== IDLE) begin
          failures++; $display("FAIL streak_state11: state=%0d want %0d", dbg_state, IDLE);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_lock();
    idle_cycle();
    cyc(); set_m1(1'b1, 16'h0010, 2'b00, 16'h0000); #1;
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01 || bus.dread_addr !== 16'h0010) begin
      failures++; $display("FAIL lock_read: gnt=%b addr=%h want 01/0010", {bus.m0_gnt, bus.m1_gnt}, bus.dread_addr);
    end
    cyc();
    set_m1(1'b0, 16'h0010, 2'b01, 16'h00AB);
    set_m0(1'b0, 16'h0020, 2'b00, 16'h0000);
    #1;
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01 || bus.dwrite_en !== 2'b01 || dbg_state !== OWN1) begin
      failures++; $display("FAIL lock_write: gnt=%b en=%b state=%0d want 01/01/%0d",
                           {bus.m0_gnt, bus.m1_gnt}, bus.dwrite_en, dbg_state, OWN1);
    end
    checks++;
    if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 16'h5A5A || bus.m0_rvalid !== 1'b0) begin
      failures++; $display("FAIL lock_rsp: rv1=%b rd1=%h rv0=%b want 1/5a5a/0", bus.m1_rvalid, bus.m1_rdata, bus.m0_rvalid);
    end
    cyc(); bus.m1_req = 0; #1;
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10 || dbg_state !== IDLE || bus.dread_addr !== 16'h0020) begin
      failures++; $display("FAIL lock_release: gnt=%b state=%0d addr=%h want 10/%0d/0020",
                           {bus.m0_gnt, bus.m1_gnt}, dbg_state, bus.dread_addr, IDLE);
    end
    cyc(); bus.m0_req = 0; set_m1(1'b0, 16'h0010, 2'b00, 16'h0000); #1;
    checks++;
    if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 16'hCAFE) begin
      failures++; $display("FAIL lock_m0_rsp: rv0=%b rd0=%h want 1/cafe", bus.m0_rvalid, bus.m0_rdata);
    end
    // The locked read-modify-write changed only the low byte.
    cyc(); clear_inputs(); #1;
    checks++;
    if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 16'h5AAB) begin
      failures++; $display("FAIL lock_rmw: rv1=%b rd1=%h want 1/5aab", bus.m1_rvalid, bus.m1_rdata);
    end
  endtask

  task automatic test_back_to_back();
    idle_cycle();
    cyc(); set_m0(1'b0, 16'h0020, 2'b00, 16'h0000); #1;
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin
      failures++; $display("FAIL b2b_gnt0: gnt=%b want 10", {bus.m0_gnt, bus.m1_gnt});
    end
    cyc(); bus.m0_req = 0; set_m1(1'b0, 16'h0022, 2'b00, 16'h0000); #1;
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01 || bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 16'hCAFE || bus.m1_rvalid !== 1'b0) begin
      failures++; $display("FAIL b2b_mid: gnt=%b rv0=%b rd0=%h rv1=%b want 01/1/cafe/0",
                           {bus.m0_gnt, bus.m1_gnt}, bus.m0_rvalid, bus.m0_rdata, bus.m1_rvalid);
    end
    cyc(); clear_inputs(); #1;
    checks++;
    if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 16'hF00D || bus.m0_rvalid !== 1'b0 || bus.m0_rdata !== 16'hCAFE) begin
      failures++; $display("FAIL b2b_end: rv1=%b rd1=%h rv0=%b rd0=%h want 1/f00d/0/cafe",
                           bus.m1_rvalid, bus.m1_rdata, bus.m0_rvalid, bus.m0_rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    idle_cycle();
    cyc(); set_m0(1'b0, 16'h4002, 2'b00, 16'h0000); #1;
    checks++;
    if (bus.m0_gnt !== 1'b1) begin
      failures++; $display("FAIL rmr_gnt: gnt0=%b want 1", bus.m0_gnt);
    end
    cyc(); clear_inputs(); reset = 1'b1; #1;
    checks++;
    if (bus.m0_rvalid !== 1'b0 || bus.m0_rdata !== 16'h0000 || bus.dwrite_en !== 2'b00) begin
      failures++; $display("FAIL rmr_in_reset: rv0=%b rd0=%h en=%b want 0/0000/00", bus.m0_rvalid, bus.m0_rdata, bus.dwrite_en);
    end
    cyc(); reset = 1'b0; #1;
    checks++;
    if (bus.m0_rvalid !== 1'b0 || dbg_state !== IDLE || bus.dwrite_en !== 2'b00 || bus.m0_rdata !== 16'h0000) begin
      failures++; $display("FAIL rmr_after: rv0=%b state=%0d en=%b rd0=%h want 0/%0d/00/0000",
                           bus.m0_rvalid, dbg_state, bus.dwrite_en, bus.m0_rdata, IDLE);
    end
    cyc(); set_m0(1'b0, 16'h0022, 2'b00, 16'h0000); #1;
    checks++;
    if (bus.m0_gnt !== 1'b1 || bus.dread_addr !== 16'h0022) begin
      failures++; $display("FAIL rmr_first_gnt: gnt0=%b addr=%h want 1/0022", bus.m0_gnt, bus.dread_addr);
    end
    cyc(); clear_inputs(); #1;
    checks++;
    if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 16'hF00D) begin
      failures++; $display("FAIL rmr_first_rsp: rv0=%b rd0=%h want 1/f00d", bus.m0_rvalid, bus.m0_rdata);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[16'h4002 >> 1] = 16'h1234;
    mem[16'h0010 >> 1] = 16'h5A5A;
    mem[16'h0020 >> 1] = 16'hCAFE;
    mem[16'h0022 >> 1] = 16'hF00D;
    bus.dread_data = '0;

    test_reset();
    test_single_read();
    test_simultaneous();
    test_starvation();
    test_lock_streak();
    test_lock();
    test_back_to_back();
    test_reset_mid_read();

    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
